// File: rtl/aes128_round_ctrl.sv
// ---------------------------------------------------------------------------
// aes128_round_ctrl
// Iterative AES-128 encryption sequencer. Loads plaintext and key, applies the
// initial AddRoundKey, then runs ten rounds. Each round uses an external
// 128-bit S-box bank for SubBytes and an external 32-bit SubWord unit for key
// expansion. ShiftRows, MixColumns, AddRoundKey and the round-key schedule are
// computed here, on the fly.
//
// Parameters
//   SBOX_LAT   latency of the external S-box/SubWord units: 0 or 1 cycle
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   request valid (plaintext + key)
//   in_ready   block idle; request accepted when in_valid && in_ready
//   in_key     128-bit cipher key, byte0 = [127:120]
//   in_pt      128-bit plaintext, same byte order
//   out_valid  ciphertext valid, held until out_ready
//   out_ready  consumer accepts ciphertext
//   out_ct     ciphertext, retained after the handshake
//   busy       sequencer not idle
//   round      current round number 0..10
//   sb_in      current state, sent to the S-box bank
//   sb_out     SubBytes(sb_in), SBOX_LAT cycles later
//   sw_in      RotWord of the last round-key word, sent to the SubWord unit
//   sw_out     SubWord(sw_in), SBOX_LAT cycles later
// ---------------------------------------------------------------------------
module aes128_round_ctrl #(
   parameter int SBOX_LAT = 0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_key,
   input  logic [127:0] in_pt,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_ct,
   output logic         busy,
   output logic [3:0]   round,
   output logic [127:0] sb_in,
   input  logic [127:0] sb_out,
   output logic [31:0]  sw_in,
   input  logic [31:0]  sw_out
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RND  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t        state;
   state_t        state_next;
   logic [127:0]  st;
   logic [127:0]  rk;
   logic [127:0]  rk_next;
   logic [127:0]  shifted;
   logic [127:0]  mixed;
   logic [127:0]  st_next;
   logic [31:0]   w0n;
   logic [31:0]   w1n;
   logic [31:0]   w2n;
   logic [31:0]   w3n;
   logic          do_update;
   logic          last_round;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] r);
      case (r)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   // State bytes are column-major: byte (row r, column c) is byte 4c+r,
   // byte 0 in the top bits. Row r rotates left by r columns.
   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
         end
      end
      return o;
   endfunction

   function automatic logic [31:0] mix_col(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      a0 = col[31:24];
      a1 = col[23:16];
      a2 = col[15:8];
      a3 = col[7:0];
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         o[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
      end
      return o;
   endfunction

   // Round datapath. With a registered S-box the update happens in WAIT,
   // once sb_out/sw_out reflect the values presented during RND.
   always_comb begin
      do_update  = (SBOX_LAT == 0) ? (state == RND) : (state == WAIT);
      last_round = (round == 4'd10);
      w0n        = rk[127:96] ^ sw_out ^ {rcon(round), 24'h0};
      w1n        = rk[95:64] ^ w0n;
      w2n        = rk[63:32] ^ w1n;
      w3n        = rk[31:0] ^ w2n;
      rk_next    = {w0n, w1n, w2n, w3n};
      shifted    = shift_rows(sb_out);
      mixed      = mix_columns(shifted);
      st_next    = (last_round ? shifted : mixed) ^ rk_next;
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (in_valid) state_next = RND;
         RND: begin
            if (SBOX_LAT != 0) begin
               state_next = WAIT;
            end else if (last_round) begin
               state_next = DONE;
            end
         end
         WAIT: state_next = last_round ? DONE : RND;
         DONE: if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // FSM outputs and S-box feeds; RotWord moves the top byte of w3 to the bottom.
   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
      busy      = (state != IDLE);
      sb_in     = st;
      sw_in     = {rk[23:0], rk[31:24]};
   end

   // State, round key, round counter and ciphertext registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st     <= '0;
         rk     <= '0;
         round  <= '0;
         out_ct <= '0;
      end else if (state == IDLE && in_valid) begin
         st    <= in_pt ^ in_key;
         rk    <= in_key;
         round <= 4'd1;
      end else if (do_update) begin
         st <= st_next;
         rk <= rk_next;
         if (last_round) begin
            out_ct <= st_next;
         end else begin
            round <= round + 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_aes128_round_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aes128_round_ctrl
// Directed bench for aes128_round_ctrl. Instance dut0 uses a combinational
// S-box (SBOX_LAT=0) and dut1 a registered one (SBOX_LAT=1). The bench models
// the external S-box bank and SubWord unit, and checks the FIPS-197 vectors,
// latency, round stepping, backpressure, ignored requests, mid-operation
// reset and back-to-back operation.
// ---------------------------------------------------------------------------
module tb_aes128_round_ctrl;

   localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;

   logic clk = 1'b0;
   logic rst_n;

   logic in_valid0, in_ready0, out_valid0, out_ready0, busy0;
   logic [127:0] in_key0, in_pt0, out_ct0, sb_in0, sb_out0;
   logic [31:0] sw_in0, sw_out0;
   logic [3:0] round0;

   logic in_valid1, in_ready1, out_valid1, out_ready1, busy1;
   logic [127:0] in_key1, in_pt1, out_ct1, sb_in1, sb_out1;
   logic [31:0] sw_in1, sw_out1;
   logic [3:0] round1;

   int checks   = 0;
   int failures = 0;
   int n;

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   aes128_round_ctrl #(.SBOX_LAT(0)) dut0 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid0), .in_ready(in_ready0), .in_key(in_key0), .in_pt(in_pt0),
      .out_valid(out_valid0), .out_ready(out_ready0), .out_ct(out_ct0),
      .busy(busy0), .round(round0),
      .sb_in(sb_in0), .sb_out(sb_out0), .sw_in(sw_in0), .sw_out(sw_out0)
   );

   aes128_round_ctrl #(.SBOX_LAT(1)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid1), .in_ready(in_ready1), .in_key(in_key1), .in_pt(in_pt1),
      .out_valid(out_valid1), .out_ready(out_ready1), .out_ct(out_ct1),
      .busy(busy1), .round(round1),
      .sb_in(sb_in1), .sb_out(sb_out1), .sw_in(sw_in1), .sw_out(sw_out1)
   );

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // S-box from first principles: inverse as x^254, then the affine map.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] inv;
      logic [7:0] s;
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, x);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
              ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      return s;
   endfunction

   function automatic logic [127:0] sbox128(input logic [127:0] v);
      logic [127:0] o;
      for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(v[8*i +: 8]);
      return o;
   endfunction

   function automatic logic [31:0] sbox32(input logic [31:0] v);
      logic [31:0] o;
      for (int i = 0; i < 4; i++) o[8*i +: 8] = sbox(v[8*i +: 8]);
      return o;
   endfunction

   // Combinational S-box bank and SubWord unit for dut0.
   always_comb begin
      sb_out0 = sbox128(sb_in0);
      sw_out0 = sbox32(sw_in0);
   end

   // Registered S-box bank and SubWord unit for dut1, one cycle of latency.
   always @(posedge clk) begin
      sb_out1 <= sbox128(sb_in1);
      sw_out1 <= sbox32(sw_in1);
   end

   function automatic logic sel_valid(input int sel);
      return (sel == 0) ? out_valid0 : out_valid1;
   endfunction

   function automatic logic [3:0] sel_round(input int sel);
      return (sel == 0) ? round0 : round1;
   endfunction

   function automatic logic [127:0] sel_ct(input int sel);
      return (sel == 0) ? out_ct0 : out_ct1;
   endfunction

   // Expected round number after edge k past the accept edge.
   function automatic logic [3:0] exp_round(input int sel, input int k);
      if (sel == 0) return (k < 10) ? 4'(k + 1) : 4'd10;
      return (k < 20) ? 4'(k / 2 + 1) : 4'd10;
   endfunction

   task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Presents a request on the selected instance and returns #1 after the accept edge.
   task automatic applyStimulus(input int sel, input logic [127:0] key, input logic [127:0] pt);
      @(negedge clk);
      if (sel == 0) begin
         in_valid0 = 1'b1; in_key0 = key; in_pt0 = pt;
         checkOutput("accept_ready0", 128'(in_ready0), 128'd1);
      end else begin
         in_valid1 = 1'b1; in_key1 = key; in_pt1 = pt;
         checkOutput("accept_ready1", 128'(in_ready1), 128'd1);
      end
      @(posedge clk);
      #1;
      if (sel == 0) in_valid0 = 1'b0;
      else in_valid1 = 1'b0;
   endtask

   // Counts edges until out_valid appears; optionally checks round stepping.
   task automatic waitDone(input int sel, input bit chk_round, output int edges);
      edges = 0;
      for (int k = 1; k <= 100; k++) begin
         @(posedge clk);
         #1;
         if (chk_round) checkOutput("round_step", 128'(sel_round(sel)), 128'(exp_round(sel, k)));
         if (sel_valid(sel)) begin
            edges = k;
            break;
         end
      end
      if (edges == 0) checkOutput("out_valid_timeout", 128'd0, 128'd1);
   endtask

   // Completes the output handshake and checks the return to idle.
   task automatic handshake(input int sel);
      @(negedge clk);
      if (sel == 0) out_ready0 = 1'b1;
      else out_ready1 = 1'b1;
      @(posedge clk);
      #1;
      if (sel == 0) begin
         out_ready0 = 1'b0;
         checkOutput("hs_valid0", 128'(out_valid0), 128'd0);
         checkOutput("hs_ready0", 128'(in_ready0), 128'd1);
      end else begin
         out_ready1 = 1'b0;
         checkOutput("hs_valid1", 128'(out_valid1), 128'd0);
         checkOutput("hs_ready1", 128'(in_ready1), 128'd1);
      end
   endtask

   // Main directed sequence.
   initial begin
      rst_n = 1'b0;
      in_valid0 = 1'b0; in_key0 = '0; in_pt0 = '0; out_ready0 = 1'b0;
      in_valid1 = 1'b0; in_key1 = '0; in_pt1 = '0; out_ready1 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_in_ready", 128'(in_ready0), 128'd1);
      checkOutput("rst_out_valid", 128'(out_valid0), 128'd0);
      checkOutput("rst_out_ct", out_ct0, 128'd0);
      checkOutput("rst_busy", 128'(busy0), 128'd0);
      checkOutput("rst_round", 128'(round0), 128'd0);
      checkOutput("rst_sb_in", sb_in0, 128'd0);
      checkOutput("rst_sw_in", 128'(sw_in0), 128'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // FIPS-197 C.1 with combinational S-box
      applyStimulus(0, KEY_C1, PT_C1);
      waitDone(0, 1'b1, n);
      checkOutput("c1_latency", 128'(n), 128'd10);
      checkOutput("c1_ct", out_ct0, CT_C1);
      checkOutput("c1_done_busy", 128'(busy0), 128'd1);
      checkOutput("c1_done_in_ready", 128'(in_ready0), 128'd0);
      handshake(0);
      checkOutput("c1_ct_retained", out_ct0, CT_C1);

      // FIPS-197 App.B with registered S-box
      applyStimulus(1, KEY_B, PT_B);
      waitDone(1, 1'b1, n);
      checkOutput("appb_latency", 128'(n), 128'd20);
      checkOutput("appb_ct", out_ct1, CT_B);
      handshake(1);

      // Backpressure in DONE
      applyStimulus(0, KEY_C1, PT_C1);
      waitDone(0, 1'b0, n);
      repeat (5) begin
         @(posedge clk);
         #1;
         checkOutput("bp_valid", 128'(sel_valid(0)), 128'd1);
         checkOutput("bp_ct", sel_ct(0), CT_C1);
         checkOutput("bp_in_ready", 128'(in_ready0), 128'd0);
      end
      handshake(0);

      // New request during round 4 is ignored
      applyStimulus(0, KEY_C1, PT_C1);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("ign_round4", 128'(round0), 128'd4);
      in_valid0 = 1'b1; in_key0 = ~KEY_C1; in_pt0 = ~PT_C1;
      @(posedge clk);
      #1;
      in_valid0 = 1'b0;
      waitDone(0, 1'b0, n);
      checkOutput("ign_latency", 128'(n), 128'd6);
      checkOutput("ign_ct", out_ct0, CT_C1);
      handshake(0);

      // Reset at round 5, then a fresh request
      applyStimulus(0, KEY_C1, PT_C1);
      repeat (4) @(posedge clk);
      #1;
      checkOutput("mr_round5", 128'(round0), 128'd5);
      rst_n = 1'b0;
      #1;
      checkOutput("mr_out_valid", 128'(out_valid0), 128'd0);
      checkOutput("mr_busy", 128'(busy0), 128'd0);
      checkOutput("mr_round", 128'(round0), 128'd0);
      checkOutput("mr_in_ready", 128'(in_ready0), 128'd1);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(0, KEY_B, PT_B);
      waitDone(0, 1'b0, n);
      checkOutput("mr_latency", 128'(n), 128'd10);
      checkOutput("mr_ct", out_ct0, CT_B);
      handshake(0);

      // Back-to-back with out_ready and in_valid held high
      @(negedge clk);
      out_ready0 = 1'b1;
      in_valid0 = 1'b1; in_key0 = KEY_C1; in_pt0 = PT_C1;
      @(posedge clk);
      #1;
      checkOutput("b2b_acc1_busy", 128'(busy0), 128'd1);
      waitDone(0, 1'b0, n);
      checkOutput("b2b_lat1", 128'(n), 128'd10);
      checkOutput("b2b_ct1", out_ct0, CT_C1);
      in_key0 = KEY_B; in_pt0 = PT_B;
      @(posedge clk);
      #1;
      checkOutput("b2b_hs_valid", 128'(out_valid0), 128'd0);
      checkOutput("b2b_hs_ready", 128'(in_ready0), 128'd1);
      @(posedge clk);
      #1;
      in_valid0 = 1'b0;
      checkOutput("b2b_acc2_busy", 128'(busy0), 128'd1);
      checkOutput("b2b_acc2_round", 128'(round0), 128'd1);
      waitDone(0, 1'b0, n);
      checkOutput("b2b_lat2", 128'(n), 128'd10);
      checkOutput("b2b_ct2", out_ct0, CT_B);
      @(posedge clk);
      #1;
      out_ready0 = 1'b0;
      checkOutput("b2b_idle", 128'(in_ready0), 128'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
